jtbubl_gfx_romrq: RTL

Responder side of the graphics ROM fetch interface used by the Bubble Bobble tile/object engine. It accepts 32-bit long requests (`rom_cs`/`rom_addr`) and answers with `rom_data`/`rom_ok`. It holds the most recent long(s) in a small cache and, on a miss, fetches two consecutive 16-bit words from the SDRAM controller through a req/ack/data_rdy handshake. It sits between the GFX block and the SDRAM slot mux.

---
 rtl/jtbubl_pkg.sv | 11 +
 rtl/jtbubl_romrq_entry.sv | 20 ++
 rtl/jtbubl_gfx_romrq.sv | 85 ++++++++
 3 files changed

// File: rtl/jtbubl_pkg.sv
// jtbubl_pkg: shared widths, fetch FSM states and cache-entry layout for the GFX ROM requester
package jtbubl_pkg;
  localparam int ROM_AW = 18;
  localparam int SDRAM_AW = 22;
  typedef enum logic [1:0] {IDLE, REQ, BEAT0, BEAT1} state_t;
  typedef struct packed {
    logic valid;
    logic [ROM_AW-2:0] tag;
    logic [31:0] data;
  } entry_t;
endpackage

// File: rtl/jtbubl_romrq_entry.sv
// jtbubl_romrq_entry: one cached long with its tag, valid bit and tag compare
module jtbubl_romrq_entry
  import jtbubl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ROM_AW-2:0] i_tag,
  input  logic [31:0]       i_data,
  input  logic [ROM_AW-2:0] i_cmp,
  output logic              o_match,
  output logic [31:0]       o_data
);
  entry_t r_e;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_e <= '0;
    else if (i_we) r_e <= {1'b1, i_tag, i_data};
  assign o_match = r_e.valid && r_e.tag == i_cmp;
  assign o_data = r_e.data;
endmodule

// File: rtl/jtbubl_gfx_romrq.sv
// jtbubl_gfx_romrq: GFX ROM long cache that fetches two SDRAM words per miss
// JTBUBL_ROMRQ_2WAY_EN selects a two-entry LRU cache instead of a single entry
module jtbubl_gfx_romrq
  import jtbubl_pkg::*;
#(
  parameter logic [SDRAM_AW-1:0] BASE = 22'h0
) (
  input  logic                rst,
  input  logic                clk,
  input  logic                rom_cs,
  input  logic [ROM_AW-1:0]   rom_addr,
  output logic [31:0]         rom_data,
  output logic                rom_ok,
  output logic                sdram_req,
  output logic [SDRAM_AW-1:0] sdram_addr,
  input  logic                sdram_ack,
  input  logic                data_rdy,
  input  logic [15:0]         sdram_din
);
  state_t r_st;
  logic [ROM_AW-2:0] r_req_tag;
  logic [15:0] r_buf;
  logic w_fill;
  logic [31:0] w_fill_data;
  assign w_fill = r_st == BEAT1 && data_rdy;
  assign w_fill_data = {sdram_din, r_buf};
`ifdef JTBUBL_ROMRQ_2WAY_EN
  logic [1:0] w_match, w_hit, w_we;
  logic [31:0] w_data [2];
  logic r_lru, r_last, w_victim;
  for (genvar i = 0; i < 2; i++) begin : g_way
    jtbubl_romrq_entry u_entry (
      .clk(clk), .rst(rst), .i_we(w_we[i]), .i_tag(r_req_tag), .i_data(w_fill_data),
      .i_cmp(rom_addr[ROM_AW-1:1]), .o_match(w_match[i]), .o_data(w_data[i])
    );
  end
  assign w_hit = {2{rom_cs}} & w_match;
  // a hit in the fill cycle protects the hit entry from eviction
  assign w_victim = w_hit[0] ? 1'b1 : w_hit[1] ? 1'b0 : r_lru;
  assign w_we = {w_fill & w_victim, w_fill & ~w_victim};
  assign rom_ok = |w_hit;
  assign rom_data = w_hit[0] ? w_data[0] : w_hit[1] ? w_data[1] : w_data[r_last];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_lru <= 1'b0;
      r_last <= 1'b0;
    end else if (w_fill) begin
      r_lru <= ~w_victim;
      r_last <= w_victim;
    end else if (rom_ok) r_lru <= w_hit[0];
`else
  logic w_match;
  jtbubl_romrq_entry u_entry (
    .clk(clk), .rst(rst), .i_we(w_fill), .i_tag(r_req_tag), .i_data(w_fill_data),
    .i_cmp(rom_addr[ROM_AW-1:1]), .o_match(w_match), .o_data(rom_data)
  );
  assign rom_ok = rom_cs & w_match;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_st <= IDLE;
      r_req_tag <= '0;
      r_buf <= '0;
      sdram_req <= 1'b0;
      sdram_addr <= BASE;
    end else
      case (r_st)
        IDLE: if (rom_cs && !rom_ok) begin
          r_req_tag <= rom_addr[ROM_AW-1:1];
          sdram_addr <= BASE + {{(SDRAM_AW-ROM_AW){1'b0}}, rom_addr};
          sdram_req <= 1'b1;
          r_st <= REQ;
        end
        REQ: if (sdram_ack) begin
          sdram_req <= 1'b0;
          r_st <= BEAT0;
        end
        BEAT0: if (data_rdy) begin
          r_buf <= sdram_din;
          r_st <= BEAT1;
        end
        BEAT1: if (data_rdy) r_st <= IDLE;
        default: r_st <= IDLE;
      endcase
endmodule
